// File: rtl/frac_div_pkg.sv
// Shared constants and helpers for the fractional clock divider.
// Holds mode encodings, reset-default configuration and the config validity rule.
package frac_div_pkg;

    localparam logic MODE_SPREAD = 1'b0;
    localparam logic MODE_BLOCK  = 1'b1;

    localparam int   DEFAULT_INT  = 3;
    localparam int   DEFAULT_NUM  = 177;
    localparam int   DEFAULT_DEN  = 1250;
    localparam logic DEFAULT_MODE = MODE_SPREAD;

    // A usable configuration needs N >= 2, a non-empty frame and P < Q.
    function automatic logic cfg_is_valid(input logic [31:0] n,
                                          input logic [31:0] p,
                                          input logic [31:0] q);
        return (n >= 32'd2) && (q >= 32'd1) && (p < q);
    endfunction

endpackage

// File: rtl/frac_div_len_gen.sv
// Period-length generator: tracks the accumulator and period index of the current
// frame and reports the length of the period in progress plus a last-period flag.
module frac_div_len_gen
    import frac_div_pkg::*;
#(
    parameter int INT_W  = 8,
    parameter int FRAC_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_advance,
    input  logic [INT_W-1:0]  i_int,
    input  logic [FRAC_W-1:0] i_num,
    input  logic [FRAC_W-1:0] i_den,
    input  logic              i_mode,
    output logic [INT_W:0]    o_len,
    output logic              o_last
);

    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W-1:0] r_idx;
    logic [FRAC_W:0]   w_sum;
    logic              w_long;
    logic [FRAC_W-1:0] w_acc_next;

    assign w_sum  = {1'b0, r_acc} + {1'b0, i_num};
    assign w_long = (i_mode == MODE_BLOCK) ? (r_idx >= (i_den - i_num))
                                           : (w_sum >= {1'b0, i_den});
    // When long, acc + P - Q is below Q, so the modular FRAC_W-bit result is exact.
    assign w_acc_next = w_long ? (r_acc + i_num - i_den) : (r_acc + i_num);

    assign o_len  = {1'b0, i_int} + {{INT_W{1'b0}}, w_long};
    assign o_last = (r_idx == (i_den - {{(FRAC_W-1){1'b0}}, 1'b1}));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_idx <= '0;
        end else if (i_advance) begin
            if (o_last) begin
                r_acc <= '0;
                r_idx <= '0;
            end else begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + {{(FRAC_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/frac_clk_divider.sv
// Runtime-programmable N + P/Q clock divider producing a one-cycle strobe per period,
// with a frame marker and configuration changes deferred to frame boundaries.
module frac_clk_divider
    import frac_div_pkg::*;
#(
    parameter int   INT_W    = 8,
    parameter int   FRAC_W   = 12,
    parameter int   DEF_INT  = DEFAULT_INT,
    parameter int   DEF_NUM  = DEFAULT_NUM,
    parameter int   DEF_DEN  = DEFAULT_DEN,
    parameter logic DEF_MODE = DEFAULT_MODE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [INT_W-1:0]  cfg_int,
    input  logic [FRAC_W-1:0] cfg_num,
    input  logic [FRAC_W-1:0] cfg_den,
    input  logic              cfg_mode,
    output logic              cfg_err,
    output logic              div_clk,
    output logic              done
);

    logic [INT_W-1:0]  r_int;
    logic [FRAC_W-1:0] r_num;
    logic [FRAC_W-1:0] r_den;
    logic              r_mode;
    logic [INT_W-1:0]  r_p_int;
    logic [FRAC_W-1:0] r_p_num;
    logic [FRAC_W-1:0] r_p_den;
    logic              r_p_mode;
    logic              r_pend;
    logic              r_err;
    logic [INT_W:0]    r_cnt;
    logic              r_div;
    logic              r_done;

    logic [INT_W:0]    w_len;
    logic              w_last;
    logic              w_period_end;
    logic              w_frame_end;
    logic              w_pend_ok;

    frac_div_len_gen #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) u_len_gen (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (~enable),
        .i_advance (w_period_end),
        .i_int     (r_int),
        .i_num     (r_num),
        .i_den     (r_den),
        .i_mode    (r_mode),
        .o_len     (w_len),
        .o_last    (w_last)
    );

    assign w_period_end = enable && ((r_cnt + {{INT_W{1'b0}}, 1'b1}) == w_len);
    assign w_frame_end  = w_period_end && w_last;
    assign w_pend_ok    = cfg_is_valid(32'(r_p_int), 32'(r_p_num), 32'(r_p_den));

    assign cfg_ready = ~r_pend;
    assign cfg_err   = r_err;
    assign div_clk   = r_div;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_done <= 1'b0;
        end else if (!enable) begin
            r_cnt  <= '0;
            r_div  <= 1'b0;
            r_done <= 1'b0;
        end else if (w_period_end) begin
            r_cnt  <= '0;
            r_div  <= 1'b1;
            r_done <= w_last;
        end else begin
            r_cnt  <= r_cnt + {{INT_W{1'b0}}, 1'b1};
            r_div  <= 1'b0;
            r_done <= 1'b0;
        end
    end

    // Handshake: a config transfers on any edge with cfg_valid && cfg_ready; the
    // shadow then holds it (cfg_ready low) until it is applied at a frame boundary
    // or while disabled, or discarded with a cfg_err pulse one cycle later if invalid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_int    <= INT_W'(DEF_INT);
            r_num    <= FRAC_W'(DEF_NUM);
            r_den    <= FRAC_W'(DEF_DEN);
            r_mode   <= DEF_MODE;
            r_p_int  <= '0;
            r_p_num  <= '0;
            r_p_den  <= '0;
            r_p_mode <= 1'b0;
            r_pend   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (r_pend) begin
                if (!w_pend_ok) begin
                    r_pend <= 1'b0;
                    r_err  <= 1'b1;
                end else if (!enable || w_frame_end) begin
                    r_int  <= r_p_int;
                    r_num  <= r_p_num;
                    r_den  <= r_p_den;
                    r_mode <= r_p_mode;
                    r_pend <= 1'b0;
                end
            end else if (cfg_valid) begin
                r_p_int  <= cfg_int;
                r_p_num  <= cfg_num;
                r_p_den  <= cfg_den;
                r_p_mode <= cfg_mode;
                r_pend   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_frac_clk_divider.sv
// Directed bench for frac_clk_divider: measures strobe spacing and frame markers
// against hand-computed sequences for each configuration and interruption case.
module tb_frac_clk_divider;

    localparam int INT_W  = 8;
    localparam int FRAC_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_num;
    logic [FRAC_W-1:0] cfg_den;
    logic              cfg_mode;
    logic              cfg_err;
    logic              div_clk;
    logic              done;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int t_prev = 0;
    bit dead = 1'b0;
    int eg[8];
    int ed[8];

    int g, np, n3, n4, tot, ndone, c44, prev, rdy_bad, dis_bad;
    logic d, last_done;

    frac_clk_divider #(
        .INT_W  (INT_W),
        .FRAC_W (FRAC_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_int   (cfg_int),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .cfg_mode  (cfg_mode),
        .cfg_err   (cfg_err),
        .div_clk   (div_clk),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic next_pulse(output int gap, output logic dn);
        int k;
        gap = 0;
        dn  = 1'b0;
        if (dead) return;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (div_clk !== 1'b1 && k < 64);
        if (div_clk !== 1'b1) begin
            dead = 1'b1;
            chk("pulse_seen", int'(div_clk), 1);
        end else begin
            gap    = cyc - t_prev;
            t_prev = cyc;
            dn     = done;
        end
    endtask

    task automatic check_seq(input string tag, input int n);
        int gg;
        logic dd;
        for (int i = 0; i < n; i++) begin
            next_pulse(gg, dd);
            chk($sformatf("%s_gap%0d", tag, i), gg, eg[i]);
            chk($sformatf("%s_done%0d", tag, i), int'(dd), ed[i]);
        end
    endtask

    task automatic load_cfg(input int n, input int p, input int q, input int m);
        enable    = 1'b0;
        cfg_valid = 1'b1;
        cfg_int   = INT_W'(n);
        cfg_num   = FRAC_W'(p);
        cfg_den   = FRAC_W'(q);
        cfg_mode  = 1'(m);
        @(negedge clk);
        chk("load_busy", int'(cfg_ready), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("load_ready", int'(cfg_ready), 1);
        chk("load_err", int'(cfg_err), 0);
        enable = 1'b1;
        t_prev = cyc;
    endtask

    task automatic bad_cfg(input int n, input int p, input int q);
        cfg_valid = 1'b1;
        cfg_int   = INT_W'(n);
        cfg_num   = FRAC_W'(p);
        cfg_den   = FRAC_W'(q);
        cfg_mode  = 1'b0;
        @(negedge clk);
        chk("bad_busy", int'(cfg_ready), 0);
        chk("bad_err_early", int'(cfg_err), 0);
        cfg_valid = 1'b0;
        @(negedge clk);
        chk("bad_err", int'(cfg_err), 1);
        chk("bad_ready", int'(cfg_ready), 1);
        @(negedge clk);
        chk("bad_err_once", int'(cfg_err), 0);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        cfg_valid = 1'b0;
        cfg_int   = '0;
        cfg_num   = '0;
        cfg_den   = '0;
        cfg_mode  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_div", int'(div_clk), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(cfg_err), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        rst    = 1'b0;
        t_prev = cyc;

        // Default 3 + 177/1250, two complete frames.
        for (int f = 0; f < 2; f++) begin
            n3 = 0; n4 = 0; tot = 0; ndone = 0; c44 = 0; prev = 0; last_done = 1'b0;
            for (int i = 0; i < 1250; i++) begin
                next_pulse(g, d);
                tot += g;
                if (g == 3) n3++;
                if (g == 4) n4++;
                if (g == 4 && prev == 4) c44++;
                prev = g;
                if (d) ndone++;
                if (i == 1249) last_done = d;
            end
            chk($sformatf("f%0d_n3", f), n3, 1073);
            chk($sformatf("f%0d_n4", f), n4, 177);
            chk($sformatf("f%0d_cycles", f), tot, 3927);
            chk($sformatf("f%0d_ndone", f), ndone, 1);
            chk($sformatf("f%0d_done_last", f), int'(last_done), 1);
            chk($sformatf("f%0d_no_44", f), c44, 0);
        end

        // Mid-frame request: old pattern runs out the frame, new one starts after done.
        for (int i = 0; i < 10; i++) next_pulse(g, d);
        chk("mid_ready_before", int'(cfg_ready), 1);
        cfg_valid = 1'b1;
        cfg_int   = 8'd3;
        cfg_num   = 12'd2;
        cfg_den   = 12'd4;
        cfg_mode  = 1'b0;
        @(negedge clk);
        cfg_valid = 1'b0;
        chk("mid_ready_low", int'(cfg_ready), 0);
        np = 0; n4 = 0; rdy_bad = 0; d = 1'b0;
        while (!d && np < 1300 && !dead) begin
            next_pulse(g, d);
            np++;
            if (g == 4) n4++;
            if (!d && cfg_ready !== 1'b0) rdy_bad++;
        end
        chk("mid_pulses_to_done", np, 1240);
        chk("mid_old_n4", n4, 176);
        chk("mid_ready_held", rdy_bad, 0);
        chk("mid_ready_at_done", int'(cfg_ready), 1);
        eg = '{3, 4, 3, 4, 3, 4, 3, 4};
        ed = '{0, 0, 0, 1, 0, 0, 0, 1};
        check_seq("spread", 8);

        // Block mode 3 + 2/4.
        load_cfg(3, 2, 4, 1);
        eg = '{3, 3, 4, 4, 3, 3, 4, 4};
        ed = '{0, 0, 0, 1, 0, 0, 0, 1};
        check_seq("block", 8);

        // Integer divide by 5, one period per frame.
        load_cfg(5, 0, 1, 0);
        eg = '{5, 5, 5, 5, 5, 5, 5, 5};
        ed = '{1, 1, 1, 1, 1, 1, 1, 1};
        check_seq("int5", 4);

        // Invalid requests leave the divide-by-5 pattern running.
        bad_cfg(1, 0, 1);
        check_seq("after_bad_n", 2);
        bad_cfg(3, 4, 4);
        check_seq("after_bad_pq", 2);

        // Asynchronous reset while the strobe is high restores defaults.
        rst = 1'b1;
        #1;
        chk("async_rst_div", int'(div_clk), 0);
        chk("async_rst_done", int'(done), 0);
        repeat (2) @(negedge clk);
        chk("async_rst_ready", int'(cfg_ready), 1);
        rst    = 1'b0;
        t_prev = cyc;
        eg = '{3, 3, 3, 3, 3, 3, 3, 4};
        ed = '{0, 0, 0, 0, 0, 0, 0, 0};
        check_seq("post_rst", 8);

        // Pause for 7 cycles mid-frame; a fresh frame follows.
        @(negedge clk);
        enable  = 1'b0;
        dis_bad = 0;
        repeat (7) begin
            @(negedge clk);
            if (div_clk !== 1'b0 || done !== 1'b0) dis_bad++;
        end
        chk("disabled_quiet", dis_bad, 0);
        enable = 1'b1;
        t_prev = cyc;
        check_seq("re_enable", 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
